// File: rtl/rca_seq_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller:
// slice width, FSM state encoding and the slice-count helper.
package rca_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/RCA_4bit.sv
// Four-bit ripple-carry adder slice, shared by every nibble step of
// rca_seq_ctrl. Purely combinational.
module RCA_4bit
    import rca_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic [SLICE_W:0] carry;

    // NOTE: every variable gets a value before the loop so no latch is inferred.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < SLICE_W; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[SLICE_W];
    end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder that steps one shared 4-bit ripple slice from
// LSB to MSB nibble. Define RCA_SEQ_SUB_EN to add the sub port (a - b).
module rca_seq_ctrl
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
`ifdef RCA_SEQ_SUB_EN
    logic               sub_q;
`endif

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               s_cout;

    // Nibble mux in front of the shared slice; subtraction inverts B.
    always_comb begin
        a_nib = a_q[idx_q * SLICE_W +: SLICE_W];
        b_nib = b_q[idx_q * SLICE_W +: SLICE_W];
`ifdef RCA_SEQ_SUB_EN
        if (sub_q) begin
            b_nib = ~b_nib;
        end
`endif
    end

    RCA_4bit u_slice (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (s_nib),
        .cout_o (s_cout)
    );

    always_comb begin
        res_d = res_q;
        res_d[idx_q * SLICE_W +: SLICE_W] = s_nib;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the datapath registers share the async reset so an aborted
    // operation leaves no stale operands or partial result behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
`ifdef RCA_SEQ_SUB_EN
                        sub_q      <= sub;
                        carry_q    <= sub ? 1'b1 : cin;
`else
                        carry_q    <= cin;
`endif
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= s_cout;
                    if (idx_q == LAST_IDX) begin
                        // Publish the result only when complete so sum/cout
                        // never show a half-built value.
                        state_q     <= DONE;
                        sum_q       <= res_d;
                        cout_q      <= s_cout;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (WIDTH=16): vector table plus
// sequences for backpressure, back-to-back, mid-operation reset and subtract.
module tb_rca_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef RCA_SEQ_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) acc_q.push_back(cyc);
    end

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with out_ready low; ends at a negedge back in IDLE.
    task automatic do_op(input vec_t v);
        int n;
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
`ifdef RCA_SEQ_SUB_EN
        sub = v.sub;
`endif
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); n++;
        end
        check({v.name, " ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        check({v.name, " busy"}, busy, 1);
        check({v.name, " in_ready low"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check({v.name, " latency"}, n, 4);
        check({v.name, " sum"}, sum, v.s);
        check({v.name, " cout"}, cout, v.c);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({v.name, " valid drop"}, out_valid, 0);
        check({v.name, " in_ready back"}, in_ready, 1);
        check({v.name, " sum held"}, sum, v.s);
    endtask

    initial begin
        int n;
        int k;
        logic [15:0] res[2];

        vecs[0] = '{"wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{"cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
        vecs[2] = '{"small",   16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0};
        vecs[3] = '{"msb",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{"allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[5] = '{"ripple",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{"mixed",   16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0};
        vecs[7] = '{"zero",    16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Backpressure: result held while out_ready stays low.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("bp latency", n, 4);
        for (int i = 0; i < 3; i++) begin
            check("bp valid", out_valid, 1);
            check("bp sum", sum, 16'h3333);
            check("bp cout", cout, 0);
            check("bp in_ready", in_ready, 0);
            a = 16'hFFFF; b = 16'hFFFF; in_valid = (i == 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp still valid", out_valid, 1);
        check("bp sum stable", sum, 16'h3333);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp released", out_valid, 0);
        check("bp sum kept", sum, 16'h3333);
        @(posedge clk);
        @(negedge clk);
        check("bp no stray accept", busy, 0);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete();
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        res[0] = '0; res[1] = '0;
        for (int i = 0; i < 60 && k < 2; i++) begin
            @(negedge clk);
            if (acc_q.size() >= 1) begin
                a = 16'h00F0; b = 16'h0010;
            end
            if (out_valid) begin
                res[k] = sum; k++;
            end
        end
        in_valid = 1'b0;
        check("b2b results", k, 2);
        check("b2b sum0", res[0], 16'h0003);
        check("b2b sum1", res[1], 16'h0100);
        check("b2b accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) check("b2b spacing", acc_q[1] - acc_q[0], 6);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Reset two cycles into RUN aborts the operation.
        a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort sum", sum, 0);
        check("abort cout", cout, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("abort no result", k, 0);
        do_op('{"post-abort", 16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0});

`ifdef RCA_SEQ_SUB_EN
        do_op('{"sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        do_op('{"sub ok",     16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        do_op('{"sub cin1",   16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1});
        do_op('{"sub off",    16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Sequencing controller that performs a WIDTH-bit addition (optionally subtraction) over several cycles using a single shared 4-bit ripple-carry adder slice. It latches the operands on a valid/ready handshake, steps the slice through each nibble from LSB to MSB with a registered carry between steps, and presents the registered result on an output handshake. It sits between any wide-operand producer and consumer that trade throughput for adder area.

## Interface
- WIDTH, 16: operand/result width. Must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  controller can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to nibble 0.
- sub  in  1  subtract request. Present only with RCA_SEQ_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of the MSB nibble.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Outputs after reset: in_ready=1, out_valid=0, sum=0, cout=0, busy=0.
- in_ready = (state==IDLE). No new operand is accepted while RUN or DONE, so input and output transactions never overlap.
- IDLE, on in_valid && in_ready:
  - latch a and b into operand registers;
  - carry_reg <= cin;
  - slice index idx <= 0;
  - go to RUN.
- RUN, each cycle:
  - drive the adder slice with a_reg[4*idx+:4], b_reg[4*idx+:4] and carry_reg;
  - write the slice sum into sum_reg[4*idx+:4];
  - carry_reg <= slice cout.
  - If idx == NSLICE-1, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - out_valid=1; sum and cout = carry_reg, both held stable.
  - On out_ready, go to IDLE and drop out_valid. sum and cout keep their last values until the next result overwrites them.
- Inputs a, b, cin and sub are ignored whenever in_ready=0.
- out_ready is ignored outside DONE.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.
- Reset mid-operation (RUN or DONE) aborts the operation. The result is discarded, out_valid is never asserted for it, and all outputs return to their reset values.

## Timing
- Acceptance edge = T. RUN occupies edges T+1 .. T+NSLICE. out_valid is high from edge T+NSLICE onward (NSLICE cycles after acceptance).
- With out_ready held high, DONE lasts 1 cycle and in_ready returns high 1 cycle later.
- Maximum throughput: 1 operation per NSLICE+2 cycles.
- Combinational path per cycle: one 4-bit ripple slice plus the nibble mux. No path crosses slices within a cycle.

## Configuration
- RCA_SEQ_SUB_EN defined:
  - the sub port exists and is latched on acceptance;
  - when sub=1, RUN feeds ~b_reg nibbles to the slice and carry_reg starts at 1, ignoring cin;
  - result = a - b mod 2^WIDTH, and cout=1 means no borrow (a >= b).
- RCA_SEQ_SUB_EN undefined: the sub port is absent and the block only adds.

## Structure
- Shared package rca_seq_pkg holds:
  - SLICE_W = 4;
  - the state enum (IDLE, RUN, DONE);
  - function nslice(width) returning width/SLICE_W.
- One sub-module: the existing RCA_4bit, instantiated once as the shared slice.
- The controller, operand registers, index counter and result register live in rca_seq_ctrl.

## Test plan
All scenarios use WIDTH=16.
- Wrap-around: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; out_valid rises exactly 4 cycles after the acceptance edge.
- Carry-in: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Backpressure: result ready, out_ready held low 3 cycles -> out_valid, sum and cout stable; in_ready=0; in_valid pulses with other operands ignored. Result completes only on out_ready.
- Back-to-back: in_valid held high with 0x0001+0x0002, then 0x00F0+0x0010 -> sums 0x0003 and 0x0100, second acceptance exactly 6 cycles after the first with out_ready=1.
- Reset mid-operation: rst asserted 2 cycles into RUN -> all outputs at reset values immediately (asynchronous); a following operation 0x0007+0x0008 -> 0x000F.
- With RCA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; then a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
